// File: rtl/uart_frame_rx.sv
// Command-frame deframer behind the UART RX FIFO: SOF / LEN / payload / XOR-CHK.
// Good frames are held for the host until acked; malformed frames are dropped and counted.
module uart_frame_rx #(
    parameter int unsigned MAX_PAYLOAD    = 16,
    parameter logic [7:0]  SOF_BYTE       = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    localparam int unsigned AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    byte_in,
    input  logic          pending_in,
    input  logic          parity_err_in,
    output logic          req_data,
    output logic          frame_valid,
    output logic [7:0]    frame_len,
    input  logic          frame_ack,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          chk_error,
    output logic          len_error,
    output logic          parity_error,
    output logic          timeout_error,
    output logic [15:0]   frame_cnt,
    output logic [7:0]    err_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN     = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_CHK     = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;

    localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0]    MAX_LEN  = 9'(MAX_PAYLOAD);

    logic [2:0]    state_q, state_d;
    logic          pop_gap_q;
    logic [7:0]    len_q, len_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    acc_q, acc_d;
    logic          bad_par_q, bad_par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          chk_err_q, chk_err_d;
    logic          len_err_q, len_err_d;
    logic          par_err_q, par_err_d;
    logic          tmo_err_q, tmo_err_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [7:0]    err_cnt_q;
    logic          any_err;
    logic          pop;
    logic          in_frame;
    logic          buf_we;
    logic [7:0]    buf_q [MAX_PAYLOAD];

    assign in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
    assign pop      = pending_in && !pop_gap_q && (state_q != S_HOLD);
    assign any_err  = chk_err_d || len_err_d || par_err_d || tmo_err_d;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        bad_par_d   = bad_par_q;
        tmo_d       = '0;
        chk_err_d   = 1'b0;
        len_err_d   = 1'b0;
        par_err_d   = 1'b0;
        tmo_err_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;
        buf_we      = 1'b0;

        if (in_frame) begin
            tmo_d = pop ? '0 : tmo_q + 1'b1;
            if (pop && parity_err_in) begin
                bad_par_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (pop && (byte_in == SOF_BYTE)) begin
                    state_d   = S_LEN;
                    acc_d     = '0;
                    bad_par_d = 1'b0;
                    idx_d     = '0;
                end
            end
            S_LEN: begin
                if (pop) begin
                    if ((byte_in == 8'd0) || ({1'b0, byte_in} > MAX_LEN)) begin
                        len_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        len_d   = byte_in;
                        acc_d   = byte_in;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (pop) begin
                    buf_we = 1'b1;
                    acc_d  = acc_q ^ byte_in;
                    idx_d  = idx_q + 8'd1;
                    if (idx_q == (len_q - 8'd1)) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (pop) begin
                    // The CHK byte's own parity flag counts as part of the frame.
                    if (bad_par_q || parity_err_in) begin
                        par_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end else if (byte_in != acc_q) begin
                        chk_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (frame_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (in_frame && !pop && (tmo_q == TMO_LAST)) begin
            tmo_err_d = 1'b1;
            state_d   = S_IDLE;
        end
    end

    // pop_gap resets high so req_data stays low while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pop_gap_q   <= 1'b1;
            len_q       <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            bad_par_q   <= 1'b0;
            tmo_q       <= '0;
            chk_err_q   <= 1'b0;
            len_err_q   <= 1'b0;
            par_err_q   <= 1'b0;
            tmo_err_q   <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pop_gap_q   <= pop;
            len_q       <= len_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            bad_par_q   <= bad_par_d;
            tmo_q       <= tmo_d;
            chk_err_q   <= chk_err_d;
            len_err_q   <= len_err_d;
            par_err_q   <= par_err_d;
            tmo_err_q   <= tmo_err_d;
            frame_cnt_q <= frame_cnt_d;
            if (any_err && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[idx_q[AW-1:0]] <= byte_in;
        end
    end

    assign req_data      = pop;
    assign frame_valid   = (state_q == S_HOLD);
    assign frame_len     = len_q;
    assign rd_data       = (32'(rd_addr) < MAX_PAYLOAD) ? buf_q[rd_addr] : '0;
    assign chk_error     = chk_err_q;
    assign len_error     = len_err_q;
    assign parity_error  = par_err_q;
    assign timeout_error = tmo_err_q;
    assign frame_cnt     = frame_cnt_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
Command-frame deframer that sits directly downstream of the UART RX FIFO interface (data_out_rx / pending_data_rx / req_data / parity_error_rx). It pops bytes one at a time and hunts for a start-of-frame byte. It then collects a length-prefixed payload into an internal buffer and checks an XOR checksum. Good frames are presented to the host through a valid/ack handshake and a random-access read port; malformed frames are dropped and reported.

Parameters:
MAX_PAYLOAD, 16, maximum payload bytes per frame (1..255); sets the buffer depth.
SOF_BYTE, 8'hA5, start-of-frame marker.
TIMEOUT_CYCLES, 100000, maximum clk cycles allowed between pops inside a frame before it is aborted.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
byte_in  input  8  head byte of the RX FIFO (first-word-fall-through; valid while pending_in=1)
pending_in  input  1  RX FIFO non-empty
parity_err_in  input  1  UART RX parity error flag
req_data  output  1  one-cycle pop strobe to the RX FIFO
frame_valid  output  1  a good frame is held in the buffer
frame_len  output  8  payload length of the held frame
frame_ack  input  1  host releases the held frame
rd_addr  input  $clog2(MAX_PAYLOAD)  payload read index
rd_data  output  8  buffer[rd_addr], combinational
chk_error  output  1  one-cycle pulse: checksum mismatch
len_error  output  1  one-cycle pulse: LEN=0 or LEN>MAX_PAYLOAD
parity_error  output  1  one-cycle pulse: frame contained a parity-flagged byte
timeout_error  output  1  one-cycle pulse: inter-byte timeout
frame_cnt  output  16  good frames accepted, wraps
err_cnt  output  8  total error pulses, saturates at 255

Behaviour:
- Reset values: all outputs 0; state=IDLE; buffer contents undefined; rd_data is don't-care while frame_valid=0.
- Frame format: SOF, LEN, LEN payload bytes, CHK. CHK = XOR of LEN and all payload bytes.
- Pop rule: in IDLE/LEN/PAYLOAD/CHK, when pending_in=1 and pop_gap=0:
  - assert req_data for exactly one cycle;
  - byte_in and parity_err_in are sampled in that same cycle;
  - pop_gap=1 for the next cycle, so there are never back-to-back pops (max 1 byte per 2 cycles).
- In HOLD, req_data=0; the FIFO absorbs backpressure.
- IDLE: a popped byte equal to SOF_BYTE -> LEN, with the checksum accumulator cleared, the bad-parity flag cleared and the byte index set to 0. Any other byte is discarded silently; parity is ignored in IDLE.
- LEN: a popped value of 0 or >MAX_PAYLOAD -> len_error pulse, go to IDLE. Otherwise latch frame_len, acc=LEN, go to PAYLOAD.
- PAYLOAD: each popped byte is written to buffer[idx], XORed into acc, and idx increments. After byte frame_len-1 -> CHK. A SOF_BYTE value here is plain data; there is no resync.
- Bad-parity flag: set if parity_err_in=1 on any pop from LEN through CHK.
- CHK: on the pop, checks are applied in this priority order:
  1. Bad-parity flag set -> parity_error pulse, go to IDLE.
  2. Else byte != acc -> chk_error pulse, go to IDLE.
  3. Else -> HOLD; frame_valid=1 the cycle after the CHK pop; frame_cnt++.
- A bad-parity flag set on the LEN pop does not pre-empt LEN validation; the frame continues and is rejected at CHK.
- HOLD:
  - frame_valid, frame_len and the buffer are stable.
  - frame_ack=1 -> frame_valid=0 next cycle, go to IDLE; popping resumes the cycle after that.
  - frame_ack outside HOLD is ignored.
- Timeout:
  - Counter is cleared on every pop and on entry to LEN.
  - It increments each cycle in LEN/PAYLOAD/CHK.
  - On reaching TIMEOUT_CYCLES-1 without a pop -> timeout_error pulse, go to IDLE.
  - The counter is inactive in IDLE and HOLD.
  - If a pop and the timeout coincide, the pop wins.
- Error pulses are mutually exclusive per cycle. err_cnt increments on any error pulse and holds at 255.
- Reset mid-frame or in HOLD: return to IDLE immediately; frame_valid drops asynchronously; the partial frame is lost; counters clear.

Test Plan:
- FIFO presents A5 03 11 22 33 03 -> 6 req_data pulses at least 2 cycles apart; frame_valid=1, frame_len=3; rd_addr 0/1/2 -> 11/22/33; frame_cnt=1; after frame_ack, frame_valid=0 next cycle.
- Garbage 00 FF 5A, then a good frame A5 01 7E 7F -> the 3 garbage bytes are popped and dropped; frame_valid=1, frame_len=1, rd_data[0]=7E; no error pulses.
- A5 02 10 20 00 -> chk_error single pulse, err_cnt=1, no frame_valid. A following good frame is accepted normally.
- A5 00 and, separately, A5 11 (17>MAX_PAYLOAD) -> len_error pulse after the LEN pop each time; the parser returns to IDLE and the next byte is treated as a SOF hunt.
- A5 03 11, then no bytes for TIMEOUT_CYCLES -> timeout_error pulse; a subsequent good frame is accepted.
- Good frame with parity_err_in=1 during the 2nd payload pop -> parity_error pulse at CHK, no chk_error.
- Two good frames queued, no ack -> exactly 6 pops, then req_data stays 0 in HOLD. After ack, the second frame is parsed; frame_cnt=2.
